// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants, FSM encoding and buffer entry type for the fetch unit
package ifetch_pkg;
  localparam logic [31:0] IFETCH_RESET_ADDR = 32'h0000_3000;
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: power-of-two instruction buffer with synchronous flush taking priority over push/pop
module ifetch_fifo import ifetch_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                     Clk,
  input  logic                     ReSet_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   din,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge Clk)
    if (push && !flush) mem[wr_ptr] <= din;
  always_ff @(posedge Clk or negedge ReSet_n)
    if (!ReSet_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: issues word reads over req/ack, buffers {pc, instr} for decode, flushes on redirect
module ifetch_unit import ifetch_pkg::*; #(
  parameter logic [31:0] RESET_ADDR = IFETCH_RESET_ADDR,
  parameter int          DEPTH      = 2
) (
  input  logic        Clk,
  input  logic        ReSet_n,
  input  logic [31:0] NEWPC,
  input  logic        Redirect,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPc,
  input  logic        InstrReady
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state;
  logic [31:0] fetch_addr, drop_addr;
  logic [CW-1:0] count, count_nxt;
  logic push, pop;
  entry_t din, head;
  assign push = IMemAck && state == REQ;
  assign pop = InstrValid && InstrReady;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign din = '{pc: fetch_addr, instr: IMemData};
  assign IMemReq = state != IDLE;
  // while dropping, the bus keeps the abandoned address even if fetch_addr has moved on
  assign IMemAddr = state == DROP ? drop_addr : fetch_addr;
  assign InstrValid = count != '0;
  assign Instr = InstrValid ? head.instr : '0;
  assign InstrPc = InstrValid ? head.pc : '0;
  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk(Clk), .ReSet_n(ReSet_n), .flush(Redirect), .push(push), .pop(pop),
    .din(din), .head(head), .count(count)
  );
  always_ff @(posedge Clk or negedge ReSet_n)
    if (!ReSet_n) begin
      state      <= IDLE;
      fetch_addr <= {RESET_ADDR[31:2], 2'b00};
      drop_addr  <= {RESET_ADDR[31:2], 2'b00};
    end else if (Redirect) begin
      fetch_addr <= {NEWPC[31:2], 2'b00};
      if (state == REQ && !IMemAck) drop_addr <= fetch_addr;
      state <= (state == DROP || (state == REQ && !IMemAck)) ? DROP : REQ;
    end else if (state == IDLE) begin
      if (count < CW'(DEPTH)) state <= REQ;
    end else if (IMemAck) begin
      if (state == REQ) fetch_addr <= fetch_addr + 32'd4;
      state <= (state == DROP || count_nxt < CW'(DEPTH)) ? REQ : IDLE;
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: table vectors, corner sequences and random traffic checked against a queue model
module tb_ifetch_unit;
  import ifetch_pkg::*;
  localparam int DEPTH = 2;
  logic Clk = 0, ReSet_n = 0, Redirect = 0, IMemAck = 0, InstrReady = 0;
  logic [31:0] NEWPC = 0, IMemData = 0;
  logic IMemReq, InstrValid;
  logic [31:0] IMemAddr, Instr, InstrPc;
  int vecs = 0, errs = 0, lat = 0, wcnt = 0;
  bit rnd = 0;
  entry_t q[$];
  bit m_req, m_drop;
  logic [31:0] m_next, m_hold;
  typedef struct {
    bit rst; bit rdy; bit exp_req; logic [31:0] exp_addr; bit exp_valid; logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl[11];

  ifetch_unit #(.RESET_ADDR(32'h0000_3000), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .ReSet_n(ReSet_n), .NEWPC(NEWPC), .Redirect(Redirect),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
    .InstrValid(InstrValid), .Instr(Instr), .InstrPc(InstrPc), .InstrReady(InstrReady)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, got, exp);
    end
  endtask

  task automatic model_reset;
    q.delete();
    m_req = 0; m_drop = 0; m_next = 32'h3000; m_hold = 32'h3000; wcnt = 0;
  endtask

  // the reference: a queue of kept words, a fetch pointer and whether the bus word is wanted
  task automatic model_edge(input bit rd, input logic [31:0] np, input bit ack, input bit rdy);
    int pre;
    entry_t e;
    pre = q.size();
    if (rd) begin
      q.delete();
      if (m_req && !m_drop && !ack) begin m_drop = 1; m_hold = m_next; end
      m_req = 1;
      m_next = {np[31:2], 2'b00};
    end else begin
      if (pre > 0 && rdy) q.delete(0);
      if (!m_req) m_req = pre < DEPTH;
      else if (ack && m_drop) m_drop = 0;
      else if (ack) begin
        e.pc = m_next; e.instr = word(m_next);
        q.push_back(e);
        m_next = m_next + 32'd4;
        m_req = q.size() < DEPTH;
      end
    end
  endtask

  task automatic model_check;
    chk("model IMemReq", 32'(IMemReq), 32'(m_req));
    chk("model IMemAddr", IMemAddr, m_drop ? m_hold : m_next);
    chk("model InstrValid", 32'(InstrValid), 32'(q.size() > 0));
    chk("model InstrPc", InstrPc, q.size() > 0 ? q[0].pc : 32'h0);
    chk("model Instr", Instr, q.size() > 0 ? q[0].instr : 32'h0);
  endtask

  task automatic step(input bit rd, input logic [31:0] np, input bit rdy);
    logic req_pre, a;
    req_pre = IMemReq;
    Redirect = rd; NEWPC = np; InstrReady = rdy;
    a = IMemReq && (rnd ? ($urandom_range(0, 2) == 0 || wcnt >= 3) : wcnt >= lat);
    IMemAck = a;
    IMemData = a ? word(IMemAddr) : $urandom;
    model_edge(rd, np, a, rdy);
    @(posedge Clk); #1;
    wcnt = (!req_pre || a) ? 0 : wcnt + 1;
    Redirect = 0; IMemAck = 0;
    model_check;
  endtask

  task automatic do_reset;
    ReSet_n = 0; Redirect = 0; IMemAck = 0; InstrReady = 0;
    @(posedge Clk); #1;
    model_reset;
    chk("reset IMemReq", 32'(IMemReq), 32'h0);
    chk("reset IMemAddr", IMemAddr, 32'h3000);
    chk("reset InstrValid", 32'(InstrValid), 32'h0);
    chk("reset Instr", Instr, 32'h0);
    chk("reset InstrPc", InstrPc, 32'h0);
    ReSet_n = 1;
  endtask

  initial begin
    tbl[0]  = '{1, 1, 1, 32'h3000, 0, 32'h0};
    tbl[1]  = '{0, 1, 1, 32'h3004, 1, 32'h3000};
    tbl[2]  = '{0, 1, 1, 32'h3008, 1, 32'h3004};
    tbl[3]  = '{0, 1, 1, 32'h300C, 1, 32'h3008};
    tbl[4]  = '{1, 0, 1, 32'h3000, 0, 32'h0};
    tbl[5]  = '{0, 0, 1, 32'h3004, 1, 32'h3000};
    tbl[6]  = '{0, 0, 0, 32'h3008, 1, 32'h3000};
    tbl[7]  = '{0, 0, 0, 32'h3008, 1, 32'h3000};
    tbl[8]  = '{0, 1, 0, 32'h3008, 1, 32'h3004};
    tbl[9]  = '{0, 1, 1, 32'h3008, 0, 32'h0};
    tbl[10] = '{0, 1, 1, 32'h300C, 1, 32'h3008};
    lat = 0;
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset;
      step(0, 0, tbl[i].rdy);
      chk($sformatf("tbl%0d IMemReq", i), 32'(IMemReq), 32'(tbl[i].exp_req));
      chk($sformatf("tbl%0d IMemAddr", i), IMemAddr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d InstrValid", i), 32'(InstrValid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d InstrPc", i), InstrPc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d Instr", i), Instr, tbl[i].exp_valid ? word(tbl[i].exp_pc) : 32'h0);
    end

    // redirect while a slow response is pending
    do_reset; lat = 3;
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 32'h4002, 1);
    chk("pend hold addr", IMemAddr, 32'h3000);
    chk("pend req", 32'(IMemReq), 32'h1);
    step(0, 0, 1);
    chk("pend hold addr2", IMemAddr, 32'h3000);
    step(0, 0, 1);
    chk("pend new addr", IMemAddr, 32'h4000);
    chk("pend dropped", 32'(InstrValid), 32'h0);

    // redirect coinciding with ack and pop, then wrap-around
    do_reset; lat = 0;
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    chk("simul pre valid", 32'(InstrValid), 32'h1);
    step(1, 32'h7000, 1);
    chk("simul empty", 32'(InstrValid), 32'h0);
    chk("simul addr", IMemAddr, 32'h7000);
    step(0, 0, 1);
    chk("simul first pc", InstrPc, 32'h7000);
    step(1, 32'hFFFF_FFFE, 1);
    chk("wrap redirect addr", IMemAddr, 32'hFFFF_FFFC);
    step(0, 0, 1);
    chk("wrap next addr", IMemAddr, 32'h0);
    chk("wrap pc", InstrPc, 32'hFFFF_FFFC);
    step(0, 0, 1);
    chk("wrap pc0", InstrPc, 32'h0);

    // mid-request reset
    lat = 3;
    step(0, 0, 1); step(0, 0, 1);
    ReSet_n = 0; #1;
    chk("midrst IMemReq", 32'(IMemReq), 32'h0);
    chk("midrst InstrValid", 32'(InstrValid), 32'h0);
    chk("midrst IMemAddr", IMemAddr, 32'h3000);
    @(posedge Clk); #1;
    model_reset; ReSet_n = 1; lat = 0;
    step(0, 0, 1);
    chk("midrst restart", IMemAddr, 32'h3000);
    chk("midrst restart req", 32'(IMemReq), 32'h1);

    // two redirects while dropping
    do_reset; lat = 4;
    step(0, 0, 1);
    step(0, 0, 1);
    step(1, 32'h5000, 1);
    step(1, 32'h6000, 1);
    chk("b2b hold", IMemAddr, 32'h3000);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("b2b next", IMemAddr, 32'h6000);
    chk("b2b discarded", 32'(InstrValid), 32'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    chk("b2b pc", InstrPc, 32'h6000);

    // random traffic
    do_reset; rnd = 1;
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
